// File: rtl/uart_tx_fifo_feeder.sv
// rtl/uart_tx_fifo_feeder.sv - byte FIFO feeding a UART transmitter over a start/done handshake
// Optional build macro: UART_TXF_STATS_EN (adds sent_cnt and ovf outputs)

module uart_tx_fifo_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
`ifdef UART_TXF_STATS_EN
    ,
    output logic [15:0]       sent_cnt,
    output logic              ovf
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              tx_done_q, tx_done_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push;
    logic pop;
    logic done_rise;

    // Status flags come from the registered occupancy only, so s_ready never
    // depends combinationally on a same-cycle pop: a full FIFO refuses writes.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign s_ready   = ~full;
    assign count     = count_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign push      = s_valid & s_ready;
    assign done_rise = tx_done & ~tx_done_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: launch when data waits, finish on a fresh done edge, then one idle gap
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty)   state_d = ST_BUSY;
            ST_BUSY: if (done_rise) state_d = ST_GAP;
            ST_GAP:                state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: pop strobe and the next values of the UART-facing registers
    always_comb begin
        pop        = 1'b0;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                end
            end
            ST_BUSY: begin
                if (done_rise) begin
                    tx_start_d = 1'b0;
                end
            end
            ST_GAP: begin
                tx_start_d = 1'b0;
            end
            default: begin
                tx_start_d = 1'b0;
            end
        endcase
    end

    // Pointer, occupancy and done-edge next values; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_done_d = tx_done;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Datapath registers; reset discards buffered data by clearing the pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Storage array: written on accepted pushes, contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

`ifdef UART_TXF_STATS_EN
    logic [15:0] sent_cnt_q, sent_cnt_d;
    logic        ovf_q, ovf_d;

    assign sent_cnt = sent_cnt_q;
    assign ovf      = ovf_q;

    // Statistics next values: completed frames (wrapping) and sticky write-while-full
    always_comb begin
        sent_cnt_d = sent_cnt_q;
        ovf_d      = ovf_q | (s_valid & full);
        if ((state_q == ST_BUSY) && done_rise) begin
            sent_cnt_d = sent_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sent_cnt_q <= sent_cnt_d;
            ovf_q      <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb/tb_uart_tx_fifo_feeder.sv - self-checking bench for uart_tx_fifo_feeder

module tb_uart_tx_fifo_feeder;

    localparam int DEPTH = 16;
    localparam int N_RND = 48;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic [4:0] count;
    logic       full;
    logic       empty;
`ifdef UART_TXF_STATS_EN
    logic [15:0] sent_cnt;
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    uart_tx_fifo_feeder #(.DATA_W(8), .DEPTH(DEPTH), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef UART_TXF_STATS_EN
        ,
        .sent_cnt (sent_cnt),
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; tx_done = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        s_valid = 1'b1; s_data = b;
        tick;
        s_valid = 1'b0;
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic send_through(input logic [7:0] b);
        write_byte(b);
        tick;
        pulse_done;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    endtask

    task automatic test_single;
        do_reset;
        s_valid = 1'b1; s_data = 8'h5A;
        tick;
        s_valid = 1'b0;
        total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count_e got=%0d exp=1", count); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_e got=%b exp=0", tx_start); end
        tick;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_e1 got=%b exp=1", tx_start); end
        total++; if (tx_data !== 8'h5A) begin bad++; $display("FAIL single_data got=%h exp=5a", tx_data); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count_e1 got=%0d exp=0", count); end
        tick; tick;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_hold got=%b exp=1", tx_start); end
        pulse_done;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", tx_start); end
        tick;
        total++; if (tx_start !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL single_gap start=%b empty=%b exp 0/1", tx_start, empty); end
        tick;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", tx_start); end
    endtask

    task automatic test_full;
        do_reset;
        write_byte(8'h0F);
        for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i));
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", count); end
        total++; if (full !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL full_flags full=%b s_ready=%b exp 1/0", full, s_ready); end
        s_valid = 1'b1; s_data = 8'hAA;
        tick;
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_ignore got=%0d exp=16", count); end
`ifdef UART_TXF_STATS_EN
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", ovf); end
`endif
        pulse_done;
        tick;
        tick;
        s_valid = 1'b0;
        total++; if (count !== 5'd15) begin bad++; $display("FAIL full_pop_push got=%0d exp=15", count); end
        total++; if (tx_start !== 1'b1 || tx_data !== 8'h10) begin bad++; $display("FAIL full_first start=%b data=%h exp 1/10", tx_start, tx_data); end
        for (int i = 1; i < 16; i++) begin
            pulse_done; tick; tick;
            total++; if (tx_start !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL full_drain%0d start=%b data=%h exp 1/%h", i, tx_start, tx_data, 8'h10 + 8'(i)); end
        end
        pulse_done; tick; tick;
        total++; if (tx_start !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL full_end start=%b empty=%b exp 0/1", tx_start, empty); end
    endtask

    task automatic test_wrap;
        do_reset;
        for (int i = 0; i < 14; i++) send_through(8'(i));
        write_byte(8'hC0);
        for (int i = 1; i <= 5; i++) write_byte(8'hC0 + 8'(i));
        total++; if (count !== 5'd5) begin bad++; $display("FAIL wrap_count5 got=%0d exp=5", count); end
        pulse_done;
        tick;
        s_valid = 1'b1; s_data = 8'hC6;
        tick;
        s_valid = 1'b0;
        total++; if (count !== 5'd5) begin bad++; $display("FAIL wrap_same_edge got=%0d exp=5", count); end
        total++; if (tx_start !== 1'b1 || tx_data !== 8'hC1) begin bad++; $display("FAIL wrap_rd15 start=%b data=%h exp 1/c1", tx_start, tx_data); end
        for (int i = 2; i <= 6; i++) begin
            pulse_done; tick; tick;
            total++; if (tx_data !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", i, tx_data, 8'hC0 + 8'(i)); end
        end
        pulse_done; tick; tick;
        total++; if (empty !== 1'b1 || tx_start !== 1'b0) begin bad++; $display("FAIL wrap_end empty=%b start=%b exp 1/0", empty, tx_start); end
    endtask

    task automatic test_done_high;
        do_reset;
        tx_done = 1'b1;
        tick; tick;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL dh_idle_rise got=%b exp=0", tx_start); end
        write_byte(8'h33);
        tick;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL dh_busy got=%b exp=1", tx_start); end
        tick; tick; tick;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL dh_level_ignored got=%b exp=1", tx_start); end
        tx_done = 1'b0;
        tick; tick;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL dh_fall got=%b exp=1", tx_start); end
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL dh_fresh_rise got=%b exp=0", tx_start); end
        tick; tick;
    endtask

    task automatic test_reset_mid;
        logic seen;
        do_reset;
        for (int i = 0; i < 4; i++) write_byte(8'h40 + 8'(i));
        total++; if (count !== 5'd3 || tx_start !== 1'b1) begin bad++; $display("FAIL rm_pre count=%0d start=%b exp 3/1", count, tx_start); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (tx_start !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL rm_after start=%b count=%0d empty=%b exp 0/0/1", tx_start, count, empty); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tx_done = (i % 3 == 1);
            tick;
            if (tx_start !== 1'b0) seen = 1'b1;
        end
        tx_done = 1'b0;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_quiet got=%b exp=0", seen); end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] held, exp_b;
        logic       prev_v, prev_r, prev_start, pend;
        logic [7:0] prev_d;
        int         issued, launched, timer, post, cyc;
        do_reset;
        prev_v = 0; prev_r = 0; prev_d = 0; prev_start = 0; pend = 0; held = 0;
        issued = 0; launched = 0; timer = 0; post = 0; cyc = 0;
        while (!(launched == N_RND && tx_start == 1'b0 && post == 0 && exp_q.size() == 0) && cyc < 20000) begin
            tick;
            cyc++;
            tx_done = 1'b0;
            if (prev_v && prev_r) exp_q.push_back(prev_d);
            if (post == 1) begin
                total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rnd_drop got=%b exp=0", tx_start); end
                post = 2;
            end else if (post == 2) begin
                total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rnd_gap got=%b exp=0", tx_start); end
                pend = (exp_q.size() != 0);
                post = 3;
            end else if (post == 3) begin
                total++; if (tx_start !== pend) begin bad++; $display("FAIL rnd_relaunch got=%b exp=%b", tx_start, pend); end
                post = 0;
            end
            if (tx_start && !prev_start) begin
                launched++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_unexpected_frame data=%h exp none", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b) begin bad++; $display("FAIL rnd_order got=%h exp=%h", tx_data, exp_b); end
                end
                held  = tx_data;
                timer = $urandom_range(1, 25);
            end else if (tx_start) begin
                total++; if (tx_data !== held) begin bad++; $display("FAIL rnd_stable got=%h exp=%h", tx_data, held); end
            end
            prev_start = tx_start;
            total++;
            if (count !== 5'(exp_q.size()) || full !== (exp_q.size() == DEPTH) ||
                empty !== (exp_q.size() == 0) || s_ready !== (exp_q.size() != DEPTH)) begin
                bad++;
                $display("FAIL rnd_occ count=%0d full=%b empty=%b ready=%b exp count=%0d", count, full, empty, s_ready, exp_q.size());
            end
            if (tx_start && timer > 0) begin
                timer--;
                if (timer == 0) begin
                    tx_done = 1'b1;
                    post    = 1;
                end
            end
            if (!(prev_v && !prev_r)) begin
                if (issued < N_RND && $urandom_range(0, 2) != 0) begin
                    s_valid = 1'b1;
                    s_data  = 8'($urandom_range(10, 200));
                    issued++;
                end else begin
                    s_valid = 1'b0;
                end
            end
            prev_v = s_valid;
            prev_r = s_ready;
            prev_d = s_data;
        end
        s_valid = 1'b0;
        total++; if (cyc >= 20000) begin bad++; $display("FAIL rnd_timeout cycles=%0d limit=20000", cyc); end
        total++; if (launched != N_RND) begin bad++; $display("FAIL rnd_frames got=%0d exp=%0d", launched, N_RND); end
`ifdef UART_TXF_STATS_EN
        total++; if (sent_cnt !== 16'(N_RND)) begin bad++; $display("FAIL rnd_sent_cnt got=%0d exp=%0d", sent_cnt, N_RND); end
`endif
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; tx_done = 1'b0;
        test_reset;
        test_single;
        test_full;
        test_wrap;
        test_done_high;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
